// File: rtl/xor_checksum_accum.sv
// Streaming XOR-checksum accumulator with valid/ready on both sides.
// Optional XOR_CHK_COUNT_EN adds a saturating per-frame word counter on word_cnt.
module xor_checksum_accum #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = '0
`ifdef XOR_CHK_COUNT_EN
  , parameter int             CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             busy
`ifdef XOR_CHK_COUNT_EN
  , output logic [CNT_W-1:0] word_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] folded;
  logic             accept;

  assign accept = in_valid && in_ready;
  // First word of a frame folds against SEED directly, so no bypass path is needed.
  assign folded = ((state == IDLE) ? SEED : acc) ^ in_data;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = in_last ? HOLD : ACCUM;
      ACCUM:   if (accept && in_last) state_nxt = HOLD;
      HOLD:    if (sum_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = !reset && (state != HOLD);
    sum_valid = (state == HOLD);
    busy      = (state == ACCUM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= SEED;
      sum_out <= '0;
    end else if (accept) begin
      if (in_last) sum_out <= folded;
      else         acc     <= folded;
    end else if (state == HOLD && sum_ready) begin
      acc <= SEED;
    end
  end

`ifdef XOR_CHK_COUNT_EN
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = CNT_W'(1);
    if (state != IDLE) cnt_nxt = (&cnt) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      word_cnt <= '0;
    end else if (accept) begin
      cnt <= cnt_nxt;
      if (in_last) word_cnt <= cnt_nxt;
    end
  end
`endif

endmodule
